// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: sequencer state encoding and
// default sizing for the exp vector sequencer.
package softmax_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

  // 3-bit FSM encoding for exp_vector_seq
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } seq_state_e;

endpackage

// File: rtl/exp_vector_seq.sv
// Streams a vector of fp16 words from the source buffer through one shared
// fp16_exp unit and writes each result to the destination buffer. Owns the
// exp start/valid/clear handshake, addressing, abort and a WAIT watchdog.
module exp_vector_seq
  import softmax_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [15:0]       src_rd_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [15:0]       dst_wr_data,
  output logic              exp_start,
  output logic [15:0]       exp_input,
  output logic              exp_clear,
  input  logic              exp_valid,
  input  logic [15:0]       exp_result
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Last watchdog value before the one that trips: WAIT entered with wd=0,
  // so ERROR is reached TIMEOUT_CYC cycles after the exp_start cycle.
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT_CYC - 2);

  seq_state_e        state, nxt;
  logic [ADDR_W-1:0] src_b, dst_b;
  logic [ADDR_W:0]   len, idx;
  logic [WD_W-1:0]   wd;
  logic [15:0]       operand;
  logic              abt;        // abort seen this run (pending while in WAIT)
  logic              last_elem;

  assign last_elem = ((idx + 1'b1) == len);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = (length == '0) ? S_DONE : S_READ;
      S_READ:  nxt = abort ? S_DONE : S_LATCH;
      S_LATCH: nxt = abort ? S_DONE : S_START;
      S_START: nxt = abort ? S_DONE : S_WAIT;
      // fp16_exp must see its clear, so abort only marks pending here
      S_WAIT: begin
        if (exp_valid)         nxt = S_WRITE;
        else if (wd == WD_TRIP) nxt = S_ERROR;
      end
      S_WRITE: nxt = (last_elem || abt || abort) ? S_DONE : S_READ;
      S_DONE:  nxt = S_IDLE;
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_IDLE;
    endcase
  end

  // Run context: bases, length, element index, operand, watchdog, abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      src_b   <= '0;
      dst_b   <= '0;
      len     <= '0;
      idx     <= '0;
      wd      <= '0;
      operand <= '0;
      abt     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            abt <= 1'b0;
            idx <= '0;
            if (length != '0) begin
              src_b <= src_base;
              dst_b <= dst_base;
              len   <= length;
            end
          end
        end
        S_READ: if (abort) abt <= 1'b1;
        S_LATCH: begin
          operand <= src_rd_data;
          if (abort) abt <= 1'b1;
        end
        S_START: begin
          wd <= '0;
          if (abort) abt <= 1'b1;
        end
        S_WAIT: begin
          if (abort)      abt <= 1'b1;
          if (!exp_valid) wd  <= wd + 1'b1;
        end
        S_WRITE: begin
          idx <= idx + 1'b1;
          if (abort) abt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; addresses/data are zero when not enabled
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    aborted     = (state == S_DONE) && abt;
    err         = (state == S_ERROR);
    src_rd_en   = (state == S_READ);
    src_rd_addr = '0;
    // reset kills an in-flight write in the same cycle
    dst_wr_en   = (state == S_WRITE) && !abt && !reset;
    dst_wr_addr = '0;
    dst_wr_data = '0;
    // an abort seen in START suppresses the pulse so fp16_exp stays idle
    exp_start   = (state == S_START) && !abort;
    exp_clear   = (state == S_WRITE);
    exp_input   = operand;
    if (src_rd_en) src_rd_addr = src_b + idx[ADDR_W-1:0];
    if (dst_wr_en) begin
      dst_wr_addr = dst_b + idx[ADDR_W-1:0];
      dst_wr_data = exp_result;
    end
  end

endmodule
